lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding memory access, IDLE->REQ->WAIT->DONE.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into a trap completion.
module lsu_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        inst_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [4:0]        rd,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_rdata,
   output logic              out_valid,
   output logic [31:0]       out_rdata,
   output logic [4:0]        out_rd,
   output logic              out_reg_wen,
   output logic              out_misalign,
   output logic [1:0]        dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // once raised, mem_req_valid and its mem_* fields hold until mem_req_ready is seen.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_STORE = 3'b010;

   state_t              state_q, state_d;
   logic [5:0]          inst_q, inst_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [4:0]          rd_q, rd_d;
   logic [31:0]         rdata_q, rdata_d;

   logic                is_load;
   logic                is_store;
   logic [1:0]          size;
   logic                misalign;
   logic [4:0]          shamt;
   logic [31:0]         shifted;
   logic [31:0]         load_data;
   logic [3:0]          strb;
   logic [31:0]         wdata_rep;

   assign is_load  = (inst_q[5:3] == OP_LOAD);
   assign is_store = (inst_q[5:3] == OP_STORE);
   assign size     = inst_q[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((size == 2'b01) && addr_q[0]) ||
                     (size[1] && (addr_q[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Lane extraction and sign/zero extension of the returned word.
   always_comb begin
      shamt     = 5'd0;
      load_data = 32'd0;
      case (size)
         2'b00:   shamt = {addr_q[1:0], 3'b000};
         2'b01:   shamt = {addr_q[1], 4'b0000};
         default: shamt = 5'd0;
      endcase
      shifted = mem_rdata >> shamt;
      case (size)
         2'b00:   load_data = {{24{~inst_q[2] & shifted[7]}}, shifted[7:0]};
         2'b01:   load_data = {{16{~inst_q[2] & shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      strb      = 4'b1111;
      wdata_rep = wdata_q;
      case (size)
         2'b00: begin
            strb      = 4'b0001 << addr_q[1:0];
            wdata_rep = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            strb      = 4'b0011 << {addr_q[1], 1'b0};
            wdata_rep = {2{wdata_q[15:0]}};
         end
         default: begin
            strb      = 4'b1111;
            wdata_rep = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            // Non-memory instructions are simply dropped here.
            if (in_valid && ((inst_type[5:3] == OP_LOAD) || (inst_type[5:3] == OP_STORE))) begin
               inst_d  = inst_type;
               addr_d  = addr;
               wdata_d = wdata;
               rd_d    = rd;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (misalign) begin
               state_d = S_DONE;
            end else if (mem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               state_d = S_DONE;
               rdata_d = is_load ? load_data : 32'd0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         inst_q  <= 6'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rd_q    <= 5'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs are qualified by state so everything idles at zero outside its phase.
   always_comb begin
      in_ready      = (state_q == S_IDLE);
      mem_req_valid = (state_q == S_REQ) && !misalign;
      mem_we        = mem_req_valid && is_store;
      mem_addr      = mem_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      mem_wstrb     = mem_we ? strb : 4'b0000;
      mem_wdata     = mem_we ? wdata_rep : 32'd0;
      out_valid     = (state_q == S_DONE);
      out_misalign  = out_valid && misalign;
      out_reg_wen   = out_valid && is_load && !misalign;
      out_rdata     = out_reg_wen ? rdata_q : 32'd0;
      out_rd        = out_valid ? rd_q : 5'd0;
      dbg_state     = state_q;
   end

endmodule
